piso_tx: RTL

Parallel-in/serial-out transmitter built from a flop-based shift register and a bit counter. It accepts a WIDTH-bit word through a valid/ready handshake. It then drives the word out one bit per clock, qualified by a frame strobe. It is the transmit end of the team's serial link and pairs with a serial-in/parallel-out receiver that samples sdata on every clk edge where sframe=1.

---
 rtl/piso_tx_if.sv | 22 ++
 rtl/piso_tx.sv | 89 ++++++++
 2 files changed

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for the piso_tx transmitter.
// The master drives words in and observes the serial side; the slave is the transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             sdata;
    logic             sframe;
    logic             done;

    modport master (
        output load_valid, load_data,
        input  load_ready, sdata, sframe, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, sdata, sframe, done
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and sends it one bit per clock, framed by sframe, with done on the last bit.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    piso_tx_if.slave  bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, shreg_adv;
    logic             sdata_q, sframe_q, done_q;
    logic             sdata_nxt, sframe_nxt, done_nxt;
    logic             accept;

    assign bus.load_ready = rst & ((state == IDLE) | ((state == SHIFT) & (cnt == LAST)));
    assign accept         = bus.load_valid & bus.load_ready;

    assign shreg_adv = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    shreg_nxt = bus.load_data;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    if (accept) begin
                        cnt_nxt   = '0;
                        shreg_nxt = bus.load_data;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
                    end
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                    shreg_nxt = shreg_adv;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                shreg_nxt = '0;
            end
        endcase

        // Outputs are registered from next-state so the first bit shows one cycle after accept.
        sframe_nxt = (state_nxt == SHIFT);
        done_nxt   = sframe_nxt & (cnt_nxt == LAST);
        sdata_nxt  = sframe_nxt & (MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            sdata_q  <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shreg    <= shreg_nxt;
            sdata_q  <= sdata_nxt;
            sframe_q <= sframe_nxt;
            done_q   <= done_nxt;
        end
    end

    assign bus.sdata  = sdata_q;
    assign bus.sframe = sframe_q;
    assign bus.done   = done_q;
endmodule
